// File: rtl/tohost_dev.sv
// Memory-mapped "tohost" responder: decodes the program's exit report, buffers console bytes,
// and exposes free-running cycle/retire counters on a single-outstanding request/response bus.
module tohost_dev #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        inst_retire,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] test_code
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {RUN, DONE} state_t;
    state_t state;

    logic [31:0]   fromhost;
    logic [31:0]   cycle_cnt;
    logic [31:0]   instret_cnt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          hit;
    logic [2:0]    offset;
    logic          fifo_full;
    logic          putchar_wr;
    logic          accept;
    logic          push;
    logic          pop;
    logic          tohost_exit;
    logic [31:0]   rdata_next;

    assign hit        = (req_addr[31:5] == BASE_ADDR[31:5]) && (req_addr[1:0] == 2'b00);
    assign offset     = req_addr[4:2];
    assign fifo_full  = (count == FULL_CNT);
    assign putchar_wr = req_valid && req_we && hit && (offset == 3'd4);

    // A PUTCHAR write into a full FIFO is held off rather than dropped.
    assign req_ready  = !rsp_valid && !(putchar_wr && fifo_full);
    assign accept     = req_valid && req_ready;
    assign push       = accept && putchar_wr;
    assign pop        = char_valid && char_ready;
    assign tohost_exit = accept && req_we && hit && (offset == 3'd0) &&
                         (req_wstrb == 4'hF) && req_wdata[0];

    assign char_valid = (count != '0);
    assign char_data  = char_valid ? fifo_mem[rd_ptr] : '0;

    always_comb begin
        rdata_next = '0;
        if (!req_we && hit) begin
            case (offset)
                3'd1:    rdata_next = fromhost;
                3'd2:    rdata_next = cycle_cnt;
                3'd3:    rdata_next = instret_cnt;
                3'd5:    rdata_next = {29'b0, fifo_full, test_pass, test_done};
                default: rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_rdata <= accept ? rdata_next : '0;
            rsp_err   <= accept && !hit;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            fromhost <= '0;
        end else if (accept && req_we && hit && (offset == 3'd1)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (req_wstrb[b]) fromhost[8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state     <= RUN;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            test_code <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (tohost_exit) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                        test_code <= req_wdata[31:1];
                        test_pass <= (req_wdata[31:1] == 31'd0);
                    end
                end
                DONE: state <= DONE;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= req_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
